// File: rtl/apb_pkg.sv
// Shared APB definitions for the team's master and completer blocks.
//   slave_state_e : completer FSM states
//   state_e       : master FSM states
//   APB_*_WIDTH   : default bus widths
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH = 32;
   localparam int unsigned APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } slave_state_e;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

endpackage

// File: rtl/apb_regfile.sv
// Word register file behind the APB completer.
// Register 0 is the constant ID_VALUE; registers 1..NUM_REGS-1 are read/write and reset to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write enable (writes to index 0 are discarded)
//   widx/wdata : write index and data
//   ridx/rdata : combinational read port
module apb_regfile #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [31:0] ID_VALUE   = 32'hA9B0_0001,
   localparam int unsigned IDXW      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IDXW-1:0]       widx,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDXW-1:0]       ridx,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // Entry 0 is never written; the read mux substitutes the ID constant for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (widx != '0)) begin
         regs_q[widx] <= wdata;
      end
   end

   always_comb begin
      rdata = regs_q[ridx];
      if (ridx == '0) begin
         rdata = DATA_WIDTH'(ID_VALUE);
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a small word-addressed register file.
// Setup-phase address/direction/data/error are latched and used for the whole transfer;
// WAIT_STATES access cycles with PREADY low precede the completion cycle.
// Ports:
//   PCLK, PRESETn           : clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE   : APB control
//   PADDR, PWDATA           : byte address, write data
//   PREADY, PRDATA, PSLVERR : completion, read data, error (all from registered state)
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned ALSB   = $clog2(NBYTES);
   localparam int unsigned IDXW   = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * NBYTES);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slave_state_e          state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  setup;
   logic [IDXW-1:0]       paddr_idx;
   logic                  setup_err;
   logic                  rf_we;
   logic [IDXW-1:0]       rf_ridx;
   logic [DATA_WIDTH-1:0] rf_rdata;

   assign setup     = PSEL && !PENABLE;
   assign paddr_idx = PADDR[ALSB +: IDXW];
   assign setup_err = (|PADDR[ALSB-1:0]) || (PADDR >= ADDR_LIMIT) ||
                      (PWRITE && (paddr_idx == '0));

   // With no wait states the read data is captured straight out of the setup cycle,
   // before idx_q holds the index.
   assign rf_ridx = (state_q == S_IDLE) ? paddr_idx : idx_q;
   assign rf_we   = (state_q == S_RESP) && wr_q && !err_q;

   apb_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ID_VALUE   (ID_VALUE)
   ) u_regfile (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (rf_we),
      .widx  (idx_q),
      .wdata (wdata_q),
      .ridx  (rf_ridx),
      .rdata (rf_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = '0; // PRDATA is non-zero only during the completion cycle
      unique case (state_q)
         S_IDLE: begin
            if (setup) begin
               idx_d   = paddr_idx;
               wr_d    = PWRITE;
               wdata_d = PWDATA;
               err_d   = setup_err;
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = S_RESP;
                  rdata_d = (PWRITE || setup_err) ? '0 : rf_rdata;
               end
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               rdata_d = (wr_q || err_q) ? '0 : rf_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign PREADY  = (state_q == S_RESP);
   assign PSLVERR = (state_q == S_RESP) && err_q;
   assign PRDATA  = rdata_q;

endmodule
